// File: rtl/f1_reaction_timer_if.sv
// f1_reaction_timer_if
//   Bus between the start-light side (master: light pattern, timebase strobe,
//   driver button) and the reaction timer (slave: latched result and status).
//   Signals:
//     tick       master->slave  single-cycle timebase strobe
//     lights     master->slave  8-bit start-light pattern
//     btn        master->slave  driver button level, synchronous to clk
//     time_out   slave->master  latched reaction time in ticks (all-ones = timeout)
//     valid      slave->master  time_out holds a result from the current sequence
//     jump_start slave->master  button pressed while lights were lit
//     busy       slave->master  sequence or timing in progress
interface f1_reaction_timer_if #(
    parameter int WIDTH = 16
);
    logic             tick;
    logic [7:0]       lights;
    logic             btn;
    logic [WIDTH-1:0] time_out;
    logic             valid;
    logic             jump_start;
    logic             busy;

    modport master (
        output tick, lights, btn,
        input  time_out, valid, jump_start, busy
    );

    modport slave (
        input  tick, lights, btn,
        output time_out, valid, jump_start, busy
    );
endinterface

// File: rtl/f1_reaction_timer.sv
// f1_reaction_timer
//   Follows the start-light pattern, starts counting ticks on lights-out
//   (all-ones followed by all-zeros) and latches the count when the driver
//   presses the button. A press while any light is lit flags a jump start.
//   The result stays on display until the next light sequence begins.
//   Ports:
//     clk  system clock
//     rst  asynchronous active-low reset
//     bus  f1_reaction_timer_if slave modport (tick/lights/btn in,
//          time_out/valid/jump_start/busy out)
//   Parameters:
//     WIDTH  reaction counter / time_out width; counter saturates at 2^WIDTH-1
module f1_reaction_timer #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    f1_reaction_timer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEQ    = 3'd1,
        ARMED  = 3'd2,
        TIMING = 3'd3,
        DONE   = 3'd4,
        FAULT  = 3'd5
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    state_t           state, state_d;
    logic [WIDTH-1:0] count, count_d;
    logic [WIDTH-1:0] time_q, time_d;
    logic             valid_q, valid_d;
    logic             jump_q, jump_d;
    logic             btn_q;
    logic             press;

    // Rising edge of the button: a held button yields a single press.
    assign press = bus.btn & ~btn_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            count   <= '0;
            time_q  <= '0;
            valid_q <= 1'b0;
            jump_q  <= 1'b0;
            btn_q   <= 1'b0;
        end else begin
            state   <= state_d;
            count   <= count_d;
            time_q  <= time_d;
            valid_q <= valid_d;
            jump_q  <= jump_d;
            btn_q   <= bus.btn;
        end
    end

    always_comb begin
        state_d = state;
        count_d = count;
        time_d  = time_q;
        valid_d = valid_q;
        jump_d  = jump_q;
        case (state)
            IDLE: begin
                if (bus.lights != 8'h00) begin
                    state_d = SEQ;
                    valid_d = 1'b0;
                    jump_d  = 1'b0;
                end
            end
            SEQ: begin
                if (press) begin
                    state_d = FAULT;
                    jump_d  = 1'b1;
                end else if (bus.lights == 8'hFF) begin
                    state_d = ARMED;
                end else if (bus.lights == 8'h00) begin
                    state_d = IDLE;
                end
            end
            ARMED: begin
                if (press) begin
                    state_d = FAULT;
                    jump_d  = 1'b1;
                end else if (bus.lights == 8'h00) begin
                    // A tick on this edge is deliberately not counted.
                    state_d = TIMING;
                    count_d = '0;
                end else if (bus.lights != 8'hFF) begin
                    state_d = IDLE;
                end
            end
            TIMING: begin
                // Press wins over a coincident tick: latch the pre-increment count.
                if (press) begin
                    state_d = DONE;
                    time_d  = count;
                    valid_d = 1'b1;
                end else if (bus.tick) begin
                    if (count == CNT_MAX) begin
                        state_d = DONE;
                        time_d  = CNT_MAX;
                        valid_d = 1'b1;
                    end else begin
                        count_d = count + 1'b1;
                    end
                end
            end
            DONE: begin
                // time_out is kept until the next result overwrites it.
                if (bus.lights != 8'h00) begin
                    state_d = SEQ;
                    valid_d = 1'b0;
                    jump_d  = 1'b0;
                end
            end
            FAULT: begin
                // jump_start survives into IDLE; cleared on the next IDLE->SEQ.
                if (bus.lights == 8'h00) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.time_out   = time_q;
    assign bus.valid      = valid_q;
    assign bus.jump_start = jump_q;
    assign bus.busy       = (state == SEQ) || (state == ARMED) || (state == TIMING);
endmodule

// File: doc/f1_reaction_timer.md
Name: f1_reaction_timer

Overview:
- Downstream consumer of the F1 start-light FSM's 8-bit light bus.
- Tracks the light sequence.
- Starts timing on lights-out (all-ones followed by all-zeros).
- Measures the driver's reaction in tick units (normally 1 ms strobes from the tick generator).
- Flags a jump start if the button is pressed while any light is on.
- Result is held for display until the next light sequence begins.

Parameters:
- WIDTH, 16, width of the reaction counter and the time_out result; the counter saturates at 2^WIDTH-1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- tick  input  1  single-cycle timebase strobe; the counter advances only on tick
- lights  input  8  light pattern from the start-light FSM (0x00, 0x01, 0x03 … 0xFF)
- btn  input  1  driver button level, already synchronised to clk
- time_out  output  WIDTH  latched reaction time in ticks; all-ones means timeout
- valid  output  1  time_out holds a result from the current sequence
- jump_start  output  1  button was pressed while lights were lit this sequence
- busy  output  1  sequence or timing in progress

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, count=0, time_out=0, valid=0, jump_start=0, btn_q=0.
  - All outputs are low/zero during reset and on the first edge after release.
- Press detection:
  - btn_q is the registered copy of btn.
  - press = btn & ~btn_q (combinational).
  - A press is acted on at the clock edge where btn is first sampled high.
  - A held button produces exactly one press.
- States: IDLE, SEQ, ARMED, TIMING, DONE, FAULT.
- IDLE:
  - lights!=0 -> SEQ; on this transition clear valid and jump_start.
  - Press is ignored.
- SEQ:
  - press -> FAULT, set jump_start=1.
  - else lights==0xFF -> ARMED.
  - else lights==0 -> IDLE (aborted sequence).
- ARMED:
  - press -> FAULT, set jump_start=1.
  - else lights==0 -> TIMING, count=0.
  - else lights!=0xFF -> IDLE (abort).
- TIMING:
  - press -> DONE: time_out=count (value before any same-cycle increment), valid=1.
  - Press has priority over tick in the same cycle.
  - else tick and count==2^WIDTH-1 -> DONE: time_out=all-ones, valid=1 (timeout).
  - else tick -> count+1.
  - lights changing while in TIMING is ignored.
- DONE:
  - time_out and valid are held.
  - lights!=0 -> SEQ; on this transition clear valid and jump_start; time_out keeps its old value until overwritten.
- FAULT:
  - jump_start is held; further presses are ignored.
  - lights==0 -> IDLE with jump_start still 1; it is cleared on the next IDLE->SEQ.
- busy = 1 in SEQ, ARMED and TIMING; combinational from state.
- Latency:
  - Lights-out to counting: the first tick sampled in the cycle after the TIMING entry edge counts.
  - A tick coincident with the ARMED->TIMING edge is not counted.
- time_out is only written on entry to DONE; it is never cleared except by reset.
- Reset mid-TIMING: returns to IDLE immediately; no result is produced.
- Illegal/unreached state encodings -> IDLE.

Test Plan:
- Normal run:
  - lights 0x00->0x01->…->0xFF->0x00.
  - Then 250 ticks (one every 4 clocks), then press.
  - -> time_out=250, valid=1, jump_start=0, busy=0.
- Jump start:
  - Press while lights=0x07.
  - -> jump_start=1 on the next edge, valid=0, busy=0.
  - Lights run to 0xFF then 0x00 -> state IDLE, jump_start still 1.
  - lights=0x01 -> jump_start=0.
- Press/tick coincidence:
  - In TIMING with count=9, assert press and tick in the same cycle.
  - -> time_out=9, valid=1.
- Timeout with WIDTH=4:
  - Lights-out, 15 ticks, no press -> still busy.
  - 16th tick -> time_out=0xF, valid=1.
- Held button and abort:
  - Button held high across lights-out -> no press detected; state stays TIMING.
  - Separately, lights 0xFF->0x03 -> IDLE with busy=0.
- Async reset mid-TIMING:
  - Drive rst=0 between clock edges with count=37.
  - -> outputs zero immediately; state IDLE after release; the next sequence times correctly.
